// File: rtl/fp_sqrt_pkg.sv
// Shared types, format constants and helpers for the iterative square root unit.
package fp_sqrt_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StNorm,
      StIter,
      StRound,
      StDone
   } state_e;

   typedef enum logic [2:0] {
      RmRne = 3'b000,
      RmRtz = 3'b001,
      RmRdn = 3'b010,
      RmRup = 3'b011,
      RmRmm = 3'b100
   } rm_e;

   // Format constants
   localparam int unsigned SP_EXP_W = 8;
   localparam int unsigned SP_MAN_W = 23;
   localparam int unsigned SP_BIAS  = 127;
   localparam int unsigned SP_NB    = 26;
   localparam int unsigned DP_EXP_W = 11;
   localparam int unsigned DP_MAN_W = 52;
   localparam int unsigned DP_BIAS  = 1023;
   localparam int unsigned DP_NB    = 55;

   localparam logic [63:0] SP_QNAN = 64'h0000_0000_7FC0_0000;
   localparam logic [63:0] DP_QNAN = 64'h7FF8_0000_0000_0000;

   // Datapath widths, sized for binary64; binary32 runs top-aligned in the same registers.
   localparam int unsigned ROOT_W = DP_NB;          // root bits produced
   localparam int unsigned REM_W  = DP_NB + 3;      // remainder never exceeds 2*root+3
   localparam int unsigned RAD_W  = 2 * DP_NB;      // radicand shift register
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned STEP_W = 3;

   // Number of ITER cycles for a root of nb bits at bpc bits per cycle.
   function automatic int unsigned iters(input int unsigned nb, input int unsigned bpc);
      return (nb + bpc - 1) / bpc;
   endfunction

   // Leading-zero count of a 52-bit field; 52 when the field is zero.
   function automatic logic [5:0] lzc52(input logic [51:0] v);
      logic [5:0] n;
      n = 6'd52;
      for (int i = 0; i < 52; i++) begin
         if (v[i]) n = 6'(51 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/fp_sqrt_step.sv
// Combinational restoring square-root step: retires up to BITS_PER_CYCLE root bits.
module fp_sqrt_step
   import fp_sqrt_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic [STEP_W-1:0] steps,      // number of bits to retire this cycle
   input  logic [REM_W-1:0]  rem,
   input  logic [ROOT_W-1:0] root,
   input  logic [RAD_W-1:0]  rad,
   output logic [REM_W-1:0]  rem_next,
   output logic [ROOT_W-1:0] root_next,
   output logic [RAD_W-1:0]  rad_next
);

   logic [REM_W-1:0]  r [0:BITS_PER_CYCLE];
   logic [ROOT_W-1:0] q [0:BITS_PER_CYCLE];
   logic [RAD_W-1:0]  x [0:BITS_PER_CYCLE];
   logic [REM_W-1:0]  r_sh;
   logic [REM_W-1:0]  trial;

   // Chain of single-bit steps; inactive steps pass their inputs through.
   always_comb begin
      r_sh  = '0;
      trial = '0;
      r[0]  = rem;
      q[0]  = root;
      x[0]  = rad;
      for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
         r_sh  = {r[j][REM_W-3:0], x[j][RAD_W-1 -: 2]};
         trial = {{(REM_W - ROOT_W - 2){1'b0}}, q[j], 2'b01};
         if (j < int'(steps)) begin
            x[j+1] = {x[j][RAD_W-3:0], 2'b00};
            if (r_sh >= trial) begin
               r[j+1] = r_sh - trial;
               q[j+1] = {q[j][ROOT_W-2:0], 1'b1};
            end else begin
               r[j+1] = r_sh;
               q[j+1] = {q[j][ROOT_W-2:0], 1'b0};
            end
         end else begin
            r[j+1] = r[j];
            q[j+1] = q[j];
            x[j+1] = x[j];
         end
      end
   end

   assign rem_next  = r[BITS_PER_CYCLE];
   assign root_next = q[BITS_PER_CYCLE];
   assign rad_next  = x[BITS_PER_CYCLE];

endmodule

// File: rtl/fp_sqrt_iter.sv
// Multi-cycle digit-recurrence IEEE-754 square root, binary32/binary64, valid/ready on both sides.
module fp_sqrt_iter
   import fp_sqrt_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter int unsigned TAG_W          = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      operand_a,
   input  logic             is_double_precision,
   input  logic [2:0]       rounding_mode,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      result,
   output logic [TAG_W-1:0] out_tag,
   output logic             flag_invalid,
   output logic             flag_overflow,
   output logic             flag_underflow,
   output logic             flag_inexact,
   output logic             busy
);

   state_e             state_q, state_d;
   logic [63:0]        op_q;
   logic               dp_q;
   rm_e                rm_q;
   logic [TAG_W-1:0]   tag_q;
   logic [REM_W-1:0]   rem_q, rem_nx;
   logic [ROOT_W-1:0]  root_q, root_nx;
   logic [RAD_W-1:0]   rad_q, rad_nx;
   logic [CNT_W-1:0]   cnt_q;
   logic signed [12:0] exp_q;
   logic [63:0]        result_q;
   logic               inv_q, inx_q;
   logic [STEP_W-1:0]  steps;

   // Classification / normalisation signals
   logic               sign, is_den, is_zero, is_inf, is_nan, special, spec_inv;
   logic [10:0]        exp_f, exp_max;
   logic [51:0]        frac;
   logic [63:0]        spec_res, nan_res;
   logic [5:0]         lz;
   logic [52:0]        sig53;
   logic [53:0]        sig54;
   logic signed [12:0] bias_s, exp_u, exp_e, exp_half;

   // Rounding signals
   logic [52:0]        mant;
   logic [53:0]        mant_sum;
   logic               g_bit, r_bit, sticky, inexact, inc, carry;
   logic signed [12:0] exp_b;
   logic [63:0]        round_res;
   logic               unused_bits;

   // Classify the latched operand and produce the normalised, even-exponent radicand.
   always_comb begin
      sign     = dp_q ? op_q[63] : op_q[31];
      exp_f    = dp_q ? op_q[62:52] : {3'b000, op_q[30:23]};
      frac     = dp_q ? op_q[51:0] : {op_q[22:0], 29'b0};
      exp_max  = dp_q ? 11'h7FF : 11'h0FF;
      bias_s   = dp_q ? 13'sd1023 : 13'sd127;
      nan_res  = dp_q ? DP_QNAN : SP_QNAN;
      is_den   = (exp_f == 11'd0);
      is_zero  = is_den && (frac == '0);
      is_inf   = (exp_f == exp_max) && (frac == '0);
      is_nan   = (exp_f == exp_max) && (frac != '0);
      special  = is_nan || is_zero || is_inf || sign;
      spec_res = nan_res;
      spec_inv = 1'b0;
      if (is_nan) begin
         spec_res = nan_res;
         spec_inv = ~frac[51];                   // quiet bit clear means signalling
      end else if (is_zero) begin
         spec_res = dp_q ? op_q : {32'b0, op_q[31:0]};
      end else if (sign) begin
         spec_res = nan_res;
         spec_inv = 1'b1;
      end else if (is_inf) begin
         spec_res = dp_q ? op_q : {32'b0, op_q[31:0]};
      end
      lz       = lzc52(frac) + 6'd1;
      sig53    = is_den ? ({1'b0, frac} << lz) : {1'b1, frac};
      exp_u    = is_den ? (13'sd1 - bias_s - $signed({7'b0, lz}))
                        : ($signed({2'b00, exp_f}) - bias_s);
      // Odd exponent: double the mantissa so the exponent halves exactly.
      sig54    = exp_u[0] ? {sig53, 1'b0} : {1'b0, sig53};
      exp_e    = exp_u - $signed({12'b0, exp_u[0]});
      exp_half = exp_e >>> 1;
   end

   // Bits to retire this cycle: full width except possibly the last cycle.
   always_comb begin
      if (cnt_q >= CNT_W'(BITS_PER_CYCLE)) steps = STEP_W'(BITS_PER_CYCLE);
      else                                  steps = cnt_q[STEP_W-1:0];
   end

   fp_sqrt_step #(
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .steps     (steps),
      .rem       (rem_q),
      .root      (root_q),
      .rad       (rad_q),
      .rem_next  (rem_nx),
      .root_next (root_nx),
      .rad_next  (rad_nx)
   );

   // Round the root (positive sign, so RDN behaves as RTZ and RUP bumps on inexact).
   always_comb begin
      if (dp_q) mant = root_q[54:2];
      else      mant = {29'b0, root_q[25:2]};
      g_bit   = root_q[1];
      r_bit   = root_q[0];
      sticky  = (rem_q != '0);
      inexact = g_bit | r_bit | sticky;
      case (rm_q)
         RmRtz, RmRdn: inc = 1'b0;
         RmRup:        inc = inexact;
         RmRmm:        inc = g_bit;
         default:      inc = g_bit & (r_bit | sticky | mant[0]);
      endcase
      mant_sum = {1'b0, mant} + {53'b0, inc};
      carry    = dp_q ? mant_sum[53] : mant_sum[24];
      exp_b    = exp_q + bias_s + $signed({12'b0, carry});
      if (dp_q) begin
         round_res = {1'b0, exp_b[10:0], (carry ? 52'b0 : mant_sum[51:0])};
      end else begin
         round_res = {32'b0, 1'b0, exp_b[7:0], (carry ? 23'b0 : mant_sum[22:0])};
      end
   end

   assign unused_bits = ^{exp_b[12:11]};

   // Next-state logic; flush overrides everything.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (in_valid) state_d = StNorm;
         StNorm:  state_d = special ? StDone : StIter;
         StIter:  if (cnt_q <= CNT_W'(BITS_PER_CYCLE)) state_d = StRound;
         StRound: state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (flush) state_d = StIdle;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Datapath registers: operand capture, recurrence and result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         dp_q     <= 1'b0;
         rm_q     <= RmRne;
         tag_q    <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         rad_q    <= '0;
         cnt_q    <= '0;
         exp_q    <= '0;
         result_q <= '0;
         inv_q    <= 1'b0;
         inx_q    <= 1'b0;
      end else if (!flush) begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  op_q  <= operand_a;
                  dp_q  <= is_double_precision;
                  rm_q  <= rm_e'(rounding_mode);
                  tag_q <= in_tag;
               end
            end
            StNorm: begin
               if (special) begin
                  result_q <= spec_res;
                  inv_q    <= spec_inv;
                  inx_q    <= 1'b0;
               end else begin
                  rem_q  <= '0;
                  root_q <= '0;
                  rad_q  <= {sig54, 56'b0};
                  cnt_q  <= dp_q ? CNT_W'(DP_NB) : CNT_W'(SP_NB);
                  exp_q  <= exp_half;
               end
            end
            StIter: begin
               rem_q  <= rem_nx;
               root_q <= root_nx;
               rad_q  <= rad_nx;
               cnt_q  <= cnt_q - {3'b000, steps};
            end
            StRound: begin
               result_q <= round_res;
               inv_q    <= 1'b0;
               inx_q    <= inexact;
            end
            default: ;
         endcase
      end
   end

   assign in_ready       = (state_q == StIdle);
   assign out_valid      = (state_q == StDone);
   assign busy           = (state_q != StIdle);
   assign result         = result_q;
   assign out_tag        = tag_q;
   assign flag_invalid   = inv_q;
   assign flag_inexact   = inx_q;
   assign flag_overflow  = 1'b0;
   assign flag_underflow = 1'b0;

endmodule
